ifu_fetch: RTL

//   Instruction fetch unit: the consumer of the next-PC value. Owns the architectural PC register.

---
 rtl/ifu_pkg.sv | 15 +
 rtl/ifu_fetch.sv | 133 +++++++++++++
 2 files changed

// File: rtl/ifu_pkg.sv
// Shared types and constants for the instruction fetch unit.
// Contents: FSM state enum, canonical NOP encoding, default reset PC.
package ifu_pkg;

    typedef enum logic [1:0] {
        REQ      = 2'd0,
        WAIT_RSP = 2'd1,
        HOLD     = 2'd2,
        WAIT_UPD = 2'd3
    } ifu_state_e;

    localparam logic [31:0] INST_NOP         = 32'h0000_0013;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h8000_0000;

endpackage

// File: rtl/ifu_fetch.sv
// Instruction fetch unit for a non-pipelined multicycle core.
// Owns the architectural PC and keeps at most one fetch in flight.
//
// Ports:
//   clk, rst          core clock; synchronous active-low reset
//   next_pc/pc_update next PC and retire strobe from next-PC logic
//   imem_req_*        fetch request channel (valid/ready, addr = pc)
//   imem_rsp_*        fetch response channel (valid/ready, data, err)
//   inst_valid/ready  handshake towards decode
//   inst, inst_pc     registered instruction word and its PC
//   fetch_fault       qualifies inst_valid: fetch failed, inst = NOP
//
// Build option:
//   IFU_MISALIGN_CHK_EN  when defined, a PC with pc[1:0] != 0 issues no
//                        memory request and yields a faulting NOP instead.
module ifu_fetch
    import ifu_pkg::*;
#(
    parameter int                XLEN     = 32,
    parameter logic [XLEN-1:0]   RESET_PC = XLEN'(DEFAULT_RESET_PC)
)(
    input  logic            clk,
    input  logic            rst,
    input  logic [XLEN-1:0] next_pc,
    input  logic            pc_update,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_rsp_valid,
    output logic            imem_rsp_ready,
    input  logic [XLEN-1:0] imem_rsp_data,
    input  logic            imem_rsp_err,
    output logic            inst_valid,
    input  logic            inst_ready,
    output logic [XLEN-1:0] inst,
    output logic [XLEN-1:0] inst_pc,
    output logic            fetch_fault
);

    localparam logic [XLEN-1:0] L_NOP = XLEN'(INST_NOP);

    ifu_state_e      r_state;
    logic [XLEN-1:0] r_pc;
    logic [XLEN-1:0] r_inst;
    logic [XLEN-1:0] r_inst_pc;
    logic            r_fault;

    logic w_in_req;
    logic w_in_wait_rsp;
    logic w_in_hold;
    logic w_misalign;
    logic w_req_hs;
    logic w_rsp_hs;
    logic w_inst_hs;

    assign w_in_req      = (r_state == REQ);
    assign w_in_wait_rsp = (r_state == WAIT_RSP);
    assign w_in_hold     = (r_state == HOLD);

`ifdef IFU_MISALIGN_CHK_EN
    assign w_misalign = (r_pc[1:0] != 2'b00);
`else
    assign w_misalign = 1'b0;
`endif

    // Handshake outputs are forced low while reset is held so that
    // nothing downstream sees a request from a partially reset unit.
    assign imem_req_valid = rst & w_in_req & ~w_misalign;
    assign imem_rsp_ready = rst & w_in_wait_rsp;
    assign inst_valid     = rst & w_in_hold;

    assign imem_req_addr = r_pc;
    assign inst          = r_inst;
    assign inst_pc       = r_inst_pc;
    assign fetch_fault   = r_fault;

    assign w_req_hs  = imem_req_valid & imem_req_ready;
    assign w_rsp_hs  = imem_rsp_valid & imem_rsp_ready;
    assign w_inst_hs = inst_valid & inst_ready;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state   <= REQ;
            r_pc      <= RESET_PC;
            r_inst    <= L_NOP;
            r_inst_pc <= RESET_PC;
            r_fault   <= 1'b0;
        end else begin
            unique case (r_state)
                REQ: begin
                    if (w_misalign) begin
                        r_inst    <= L_NOP;
                        r_inst_pc <= r_pc;
                        r_fault   <= 1'b1;
                        r_state   <= HOLD;
                    end else if (w_req_hs) begin
                        r_state <= WAIT_RSP;
                    end
                end
                WAIT_RSP: begin
                    if (w_rsp_hs) begin
                        r_inst    <= imem_rsp_err ? L_NOP : imem_rsp_data;
                        r_inst_pc <= r_pc;
                        r_fault   <= imem_rsp_err;
                        r_state   <= HOLD;
                    end
                end
                HOLD: begin
                    // A retire in the same cycle as the decode handshake
                    // skips WAIT_UPD entirely.
                    if (w_inst_hs) begin
                        if (pc_update) begin
                            r_pc    <= next_pc;
                            r_state <= REQ;
                        end else begin
                            r_state <= WAIT_UPD;
                        end
                    end
                end
                WAIT_UPD: begin
                    if (pc_update) begin
                        r_pc    <= next_pc;
                        r_state <= REQ;
                    end
                end
                default: begin
                    r_state <= REQ;
                end
            endcase
        end
    end

endmodule
